// File: rtl/mm_pe_stream_pkg.sv
// Shared widths, defaults and FSM encoding for the word-serial Montgomery PE.
package mm_pe_stream_pkg;

  // Default word width (radix 2^PE_W), maximum operand length and counter width.
  localparam int PE_W         = 16;
  localparam int PE_MAX_WORDS = 256;
  localparam int PE_CNT_W     = 9;

  // Carry between word columns never exceeds W+2 bits; a column sum never exceeds 2W+2 bits.
  localparam int PE_CARRY_W = PE_W + 2;
  localparam int PE_PROD_W  = 2 * PE_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_Q      = 3'd1,
    ST_ACC0   = 3'd2,
    ST_STREAM = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } pe_state_t;

  // Derived widths for a non-default word width.
  function automatic int carry_width(input int w);
    return w + 2;
  endfunction

  function automatic int prod_width(input int w);
    return 2 * w + 2;
  endfunction

endpackage

// File: rtl/mm_pe_mac.sv
// Combinational column adder: a + b*c + d*e + f, sized so nothing is ever truncated.
module mm_pe_mac
  import mm_pe_stream_pkg::*;
#(
  parameter int W = PE_W
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic [W-1:0]   i_c,
  input  logic [W-1:0]   i_d,
  input  logic [W-1:0]   i_e,
  input  logic [W+1:0]   i_f,
  output logic [2*W+1:0] o_sum
);

  localparam int PW = prod_width(W);

  // Every operand is widened to the full column width before the arithmetic.
  assign o_sum = PW'(i_a) + PW'(i_b) * PW'(i_c) + PW'(i_d) * PW'(i_e) + PW'(i_f);

endmodule

// File: rtl/mm_pe_stream.sv
// Word-serial Montgomery PE: one outer iteration S' = (S + x*Y + q*M) / 2^W
// over a runtime length of 1..MAX_WORDS words, with valid/ready word streams.
module mm_pe_stream
  import mm_pe_stream_pkg::*;
#(
  parameter int W         = PE_W,
  parameter int MAX_WORDS = PE_MAX_WORDS,
  parameter int CNT_W     = PE_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] n_words,
  input  logic [W-1:0]     x_j,
  input  logic [W-1:0]     m_prime,
  input  logic [W-1:0]     s_hi,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     y_i,
  input  logic [W-1:0]     m_i,
  input  logic [W-1:0]     s_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_word,
  output logic [W-1:0]     out_top,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = carry_width(W);
  localparam int PW = prod_width(W);

  // Control state and operands latched at start.
  pe_state_t        r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_idx;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_mp;
  logic [W-1:0]     r_shi;

  // Word-0 operands held for the ACC0 cycle, plus the quotient digit.
  logic [W-1:0]     r_q;
  logic [W-1:0]     r_y0;
  logic [W-1:0]     r_m0;
  logic [W-1:0]     r_s0;
  logic [CW-1:0]    r_carry;

  // Registered outputs.
  logic             r_out_valid;
  logic [W-1:0]     r_out_word;
  logic [W-1:0]     r_out_top;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  // Datapath wires.
  logic             w_n_legal;
  logic             w_out_free;
  logic             w_last;
  logic             w_acc0;
  logic [W-1:0]     w_q_lin;
  logic [W-1:0]     w_q;
  logic [W-1:0]     w_mac_a;
  logic [W-1:0]     w_mac_c;
  logic [W-1:0]     w_mac_e;
  logic [CW-1:0]    w_mac_f;
  logic [PW-1:0]    w_t;
  logic [W+2:0]     w_u;

  assign w_n_legal  = (n_words != '0) && (n_words <= CNT_W'(MAX_WORDS));
  assign w_out_free = !r_out_valid || out_ready;
  assign w_last     = (r_idx == (r_n - CNT_W'(1)));
  assign w_acc0     = (r_state == ST_ACC0);

  // Quotient digit only needs the low word: all arithmetic here is mod 2^W.
  assign w_q_lin = s_i + r_x * y_i;
  assign w_q     = w_q_lin * r_mp;

  // One shared column adder: ACC0 replays the held word 0 with no carry-in,
  // STREAM consumes the live input word with the running carry.
  assign w_mac_a = w_acc0 ? r_s0 : s_i;
  assign w_mac_c = w_acc0 ? r_y0 : y_i;
  assign w_mac_e = w_acc0 ? r_m0 : m_i;
  assign w_mac_f = w_acc0 ? '0   : r_carry;

  mm_pe_mac #(
    .W(W)
  ) u_mac (
    .i_a   (w_mac_a),
    .i_b   (r_x),
    .i_c   (w_mac_c),
    .i_d   (r_q),
    .i_e   (w_mac_e),
    .i_f   (w_mac_f),
    .o_sum (w_t)
  );

  // Final column: pending carry plus the previous top word of S.
  assign w_u = (W+3)'(r_carry) + (W+3)'(r_shi);

  // Input is taken while computing q, or in STREAM whenever the output slot can take a result.
  assign in_ready = (r_state == ST_Q) || ((r_state == ST_STREAM) && w_out_free);

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_top   = r_out_top;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

  // Main control FSM with the single-entry output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_idx       <= '0;
      r_x         <= '0;
      r_mp        <= '0;
      r_shi       <= '0;
      r_q         <= '0;
      r_y0        <= '0;
      r_m0        <= '0;
      r_s0        <= '0;
      r_carry     <= '0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_top   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      // A consumed result frees the slot unless a new one is loaded below.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (!w_n_legal) begin
              r_err <= 1'b1;
            end else begin
              r_n       <= n_words;
              r_x       <= x_j;
              r_mp      <= m_prime;
              r_shi     <= s_hi;
              r_carry   <= '0;
              r_out_top <= '0;
              r_busy    <= 1'b1;
              r_state   <= ST_Q;
            end
          end
        end

        ST_Q: begin
          if (in_valid) begin
            r_q     <= w_q;
            r_y0    <= y_i;
            r_m0    <= m_i;
            r_s0    <= s_i;
            r_state <= ST_ACC0;
          end
        end

        ST_ACC0: begin
          // Low word of t0 is zero by choice of q; only the carry survives.
          r_carry <= w_t[PW-1:W];
          r_idx   <= CNT_W'(1);
          r_state <= (r_n > CNT_W'(1)) ? ST_STREAM : ST_FLUSH;
        end

        ST_STREAM: begin
          if (in_valid && w_out_free) begin
            r_out_word  <= w_t[W-1:0];
            r_out_valid <= 1'b1;
            r_carry     <= w_t[PW-1:W];
            if (w_last) begin
              r_state <= ST_FLUSH;
            end else begin
              r_idx <= r_idx + CNT_W'(1);
            end
          end
        end

        ST_FLUSH: begin
          if (w_out_free) begin
            r_out_word  <= w_u[W-1:0];
            r_out_valid <= 1'b1;
            r_out_top   <= W'(w_u[W+2:W]);
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (r_out_valid && out_ready) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_pe_stream.sv
// Self-checking bench for mm_pe_stream against a big-integer Montgomery model.
module tb_mm_pe_stream;

  localparam int W    = 16;
  localparam int MAXW = 256;
  localparam int CW   = 9;
  localparam int MAXN = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] n_words = '0;
  logic [W-1:0]  x_j = '0;
  logic [W-1:0]  m_prime = '0;
  logic [W-1:0]  s_hi = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  y_i = '0;
  logic [W-1:0]  m_i = '0;
  logic [W-1:0]  s_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_word;
  logic [W-1:0]  out_top;
  logic          busy;
  logic          done;
  logic          err;

  mm_pe_stream #(
    .W(W), .MAX_WORDS(MAXW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .n_words(n_words),
    .x_j(x_j), .m_prime(m_prime), .s_hi(s_hi),
    .in_valid(in_valid), .in_ready(in_ready),
    .y_i(y_i), .m_i(m_i), .s_i(s_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_top(out_top),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Operand words: ss[n] holds the top word of S (s_hi).
  logic [W-1:0] ys [0:MAXN-1];
  logic [W-1:0] ms [0:MAXN-1];
  logic [W-1:0] ss [0:MAXN];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // T = S + x*Y + q*M as whole integers; S' is T shifted down one word.
  function automatic logic [511:0] model_t(input int n, input logic [W-1:0] x, input logic [W-1:0] mp);
    logic [511:0] s_big;
    logic [511:0] y_big;
    logic [511:0] m_big;
    logic [31:0]  tmp;
    logic [W-1:0] q;
    s_big = '0;
    y_big = '0;
    m_big = '0;
    for (int i = 0; i <= n; i++) s_big = s_big | (512'(ss[i]) << (W * i));
    for (int i = 0; i < n; i++) begin
      y_big = y_big | (512'(ys[i]) << (W * i));
      m_big = m_big | (512'(ms[i]) << (W * i));
    end
    tmp = 32'(ss[0]) + 32'(x) * 32'(ys[0]);
    tmp = 32'(tmp[15:0]) * 32'(mp);
    q   = tmp[15:0];
    return s_big + 512'(x) * y_big + 512'(q) * m_big;
  endfunction

  // -M^-1 mod 2^16 for odd m0 (Newton iteration on the inverse).
  function automatic logic [W-1:0] neg_inv(input logic [W-1:0] m0);
    logic [W-1:0] inv;
    inv = m0;
    for (int i = 0; i < 4; i++) inv = inv * (16'd2 - m0 * inv);
    return (~inv) + 16'd1;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      ys[i] = W'($urandom);
      ms[i] = W'($urandom);
      ss[i] = W'($urandom);
    end
    ms[0] = ms[0] | 16'h0001;
    ss[n] = W'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_word"},  out_word,  0);
    check({tag, "_out_top"},   out_top,   0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_err"},       err,       0);
  endtask

  // One full iteration with randomized handshakes; abort_cyc >= 0 pulls reset mid-run.
  task automatic run_op(input string name, input int n, input logic [W-1:0] x, input logic [W-1:0] mp,
                        input int rdy_pct, input int abort_cyc, input bit poke);
    logic [511:0] t;
    logic [W-1:0] exp_w [0:MAXN-1];
    logic [W-1:0] exp_top;
    logic [W-1:0] got_w [$];
    logic [W-1:0] stall_word;
    logic [W-1:0] top_at_done;
    int idx, extra, cyc, err_seen;
    bit saw_done, stalled;

    t = model_t(n, x, mp);
    for (int k = 0; k < n; k++) exp_w[k] = t[W*(k+1) +: W];
    exp_top = t[W*(n+1) +: W];

    @(posedge clk); #1;
    start = 1'b1; n_words = CW'(n); x_j = x; m_prime = mp; s_hi = ss[n];
    @(posedge clk); #1;
    // Scramble the start-time inputs so a missing latch shows up in the results.
    start = 1'b0; n_words = '0; x_j = ~x; m_prime = ~mp; s_hi = ~ss[n];
    check({name, "_busy_start"}, busy, 1);
    check({name, "_err_start"}, err, 0);

    idx = 0; extra = 0; cyc = 0; err_seen = 0;
    saw_done = 1'b0; stalled = 1'b0; stall_word = '0; top_at_done = '0;
    while (!saw_done && cyc < 3000) begin
      out_ready = ($urandom_range(99) < rdy_pct);
      in_valid  = ($urandom_range(3) != 0);
      if (idx < n) begin
        y_i = ys[idx]; m_i = ms[idx]; s_i = ss[idx];
      end else begin
        y_i = W'($urandom); m_i = W'($urandom); s_i = W'($urandom);
      end
      if (poke && cyc == 3) begin
        start = 1'b1; n_words = CW'(1);
      end else begin
        start = 1'b0;
      end
      #1;
      if (stalled) begin
        check({name, "_stall_valid"}, out_valid, 1);
        check({name, "_stall_word"}, out_word, stall_word);
      end
      if (err) err_seen++;
      if (in_valid && in_ready) begin
        if (idx < n) idx++;
        else extra++;
      end
      if (out_valid && out_ready) got_w.push_back(out_word);
      stalled    = out_valid && !out_ready;
      stall_word = out_word;

      if (abort_cyc >= 0 && cyc == abort_cyc) begin
        check({name, "_busy_before_abort"}, busy, 1);
        rstn = 1'b0;
        #1;
        check_all_zero({name, "_abort"});
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check({name, "_no_done_in_reset"}, done, 0);
        rstn = 1'b1;
        $display("op %s n=%0d aborted at cycle %0d", name, n, cyc);
        return;
      end

      @(posedge clk); #1;
      cyc++;
      if (done) begin
        saw_done    = 1'b1;
        top_at_done = out_top;
        check({name, "_busy_at_done"}, busy, 0);
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    check({name, "_done_seen"}, saw_done, 1);
    check({name, "_out_count"}, got_w.size(), n);
    for (int k = 0; k < n && k < got_w.size(); k++) check($sformatf("%s_word%0d", name, k), got_w[k], exp_w[k]);
    check({name, "_out_top"}, top_at_done, exp_top);
    check({name, "_extra_accept"}, extra, 0);
    check({name, "_err_during"}, err_seen, 0);
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_top_hold"}, out_top, exp_top);
    $display("op %s n=%0d x=%04h mp=%04h outs=%0d top=%04h cycles=%0d", name, n, x, mp, got_w.size(), top_at_done, cyc);
  endtask

  task automatic err_start(input string name, input int nw);
    @(posedge clk); #1;
    start = 1'b1; n_words = CW'(nw);
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_err_pulse"}, err, 1);
    check({name, "_busy"}, busy, 0);
    @(posedge clk); #1;
    check({name, "_err_clear"}, err, 0);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_in_ready"}, in_ready, 0);
    $display("op %s n_words=%0d rejected", name, nw);
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle");

    // n=1 hand-worked case: q=0x5555, t0=0x10000, result word 1, top 0.
    ys[0] = 16'h0001; ms[0] = 16'h0003; ss[0] = 16'h0000; ss[1] = 16'h0000;
    run_op("tc1", 1, 16'h0001, 16'h5555, 100, -1, 1'b0);

    // x=0 with S=0 gives q=0 and all-zero results.
    fill_random(4);
    for (int i = 0; i <= 4; i++) ss[i] = '0;
    run_op("xzero", 4, 16'h0000, W'($urandom), 100, -1, 1'b0);

    // All-ones operands exercise the widest carries.
    for (int i = 0; i < 2; i++) begin
      ys[i] = 16'hFFFF; ms[i] = 16'hFFFF; ss[i] = 16'hFFFF;
    end
    ss[2] = 16'hFFFF;
    run_op("ones", 2, 16'hFFFF, 16'h0001, 100, -1, 1'b0);

    // Random n=8 iterations with a 50% stalling consumer.
    for (int r = 0; r < 4; r++) begin
      fill_random(8);
      run_op($sformatf("rnd%0d", r), 8, W'($urandom), neg_inv(ms[0]), 50, -1, 1'b0);
    end

    // A start while busy must be ignored.
    fill_random(8);
    run_op("poke", 8, W'($urandom), neg_inv(ms[0]), 70, -1, 1'b1);

    err_start("n0", 0);
    err_start("nmax1", MAXW + 1);

    // Random lengths including the one-word case.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, MAXN - 1);
      fill_random(n);
      run_op($sformatf("len%0d", r), n, W'($urandom), neg_inv(ms[0]), 60, -1, 1'b0);
    end

    // Reset during STREAM, then a clean one-word run.
    fill_random(8);
    run_op("abort", 8, W'($urandom), neg_inv(ms[0]), 100, 6, 1'b0);
    @(posedge clk); #1;
    check_all_zero("post_abort");
    fill_random(1);
    run_op("after", 1, W'($urandom), neg_inv(ms[0]), 100, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
